// File: rtl/accum_sequencer_pkg.sv
// Shared types for the accumulator frame/integration sequencer.
// Optional continuous mode is selected with ACCUM_SEQ_CONTINUOUS_EN.
package accum_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    // Any state other than IDLE counts as an integration in progress.
    function automatic logic busy_state(input state_t s);
        return (s != S_IDLE);
    endfunction

endpackage

// File: rtl/accum_sequencer_pair_counter.sv
// Pair-index tracker for the correlator partial-sum stream.
// Counts accepted words modulo PAIRS, realigns on sof, flags the last
// pair of a frame (eof) and keeps a sticky frame-sync error.
module accum_sequencer_pair_counter #(
    parameter int PAIRS = 540,
    parameter int PBITS = 10
) (
    input  logic clock,
    input  logic reset_n,
    input  logic valid,
    input  logic sof,
    input  logic check,
    input  logic clr,
    output logic eof,
    output logic err_now,
    output logic sync_err
);
    import accum_sequencer_pkg::*;

    localparam logic [PBITS-1:0] LAST = PBITS'(PAIRS - 1);

    logic [PBITS-1:0] idx_r;
    logic [PBITS-1:0] idx_next_s;
    logic             err_r;

    // Next index, end-of-frame strobe and sync check for the word on the input.
    always_comb begin
        idx_next_s = idx_r;
        eof        = 1'b0;
        err_now    = 1'b0;
        if (valid) begin
            if (sof) begin
                idx_next_s = PBITS'(1);
                err_now    = check & (idx_r != '0);
            end else begin
                idx_next_s = (idx_r == LAST) ? '0 : idx_r + PBITS'(1);
                eof        = (idx_r == LAST);
                err_now    = check & (idx_r == '0);
            end
        end else begin
            idx_next_s = idx_r;
        end
    end

    // Index register and sticky sync error (cleared when a new integration starts).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_r <= '0;
            err_r <= 1'b0;
        end else begin
            idx_r <= idx_next_s;
            if (clr) begin
                err_r <= 1'b0;
            end else if (err_now) begin
                err_r <= 1'b1;
            end
        end
    end

    assign sync_err = err_r;

endmodule

// File: rtl/accum_sequencer.sv
// Frame/integration controller in front of the visibility accumulator.
// Aligns to frame boundaries, forwards whole frames tagged first/last and
// pulses done_o after the accumulator pipeline has drained.
// Define ACCUM_SEQ_CONTINUOUS_EN to re-arm automatically after each integration.
module accum_sequencer #(
    parameter int CORES   = 18,
    parameter int TRATE   = 30,
    parameter int NBITS   = 5,
    parameter int TBITS   = 5,
    parameter int SBITS   = 6,
    parameter int LBITS   = 24,
    parameter int ACC_LAT = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [LBITS-1:0] frames_i,
    input  logic             valid_i,
    input  logic             sof_i,
    input  logic [SBITS-1:0] revis_i,
    input  logic [SBITS-1:0] imvis_i,
    output logic             acc_valid_o,
    output logic             acc_first_o,
    output logic             acc_last_o,
    output logic [SBITS-1:0] acc_revis_o,
    output logic [SBITS-1:0] acc_imvis_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             sync_err_o
);
    import accum_sequencer_pkg::*;

    localparam int PAIRS = CORES * TRATE;
    localparam int PBITS = NBITS + TBITS;
    localparam int FBITS = $clog2(ACC_LAT + 1);
    localparam logic [FBITS-1:0] FLUSH_LAST = FBITS'(ACC_LAT - 1);

    state_t           state_r, state_next;
    logic [LBITS-1:0] frames_r, frames_next;
    logic [LBITS-1:0] frame_cnt_r, frame_next;
    logic [FBITS-1:0] flush_cnt_r, flush_next;
    logic             stop_r, stop_next;
    logic             fwd_s, first_s, last_s, start_s, done_s, last_frame_s;
    logic             eof_s, err_now_s;

    logic             acc_valid_r, acc_first_r, acc_last_r, busy_r, done_r;
    logic [SBITS-1:0] acc_revis_r, acc_imvis_r;

    accum_sequencer_pair_counter #(
        .PAIRS (PAIRS),
        .PBITS (PBITS)
    ) u_pair_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .valid    (valid_i),
        .sof      (sof_i),
        .check    (state_r == S_RUN),
        .clr      (start_s),
        .eof      (eof_s),
        .err_now  (err_now_s),
        .sync_err (sync_err_o)
    );

    // FSM next state, frame bookkeeping and per-word forwarding decision.
    always_comb begin
        state_next   = state_r;
        frames_next  = frames_r;
        frame_next   = frame_cnt_r;
        flush_next   = '0;
        stop_next    = stop_r;
        fwd_s        = 1'b0;
        first_s      = 1'b0;
        last_s       = 1'b0;
        start_s      = 1'b0;
        done_s       = 1'b0;
        last_frame_s = (frame_cnt_r == frames_r - LBITS'(1)) | stop_r | stop_i;
        case (state_r)
            S_IDLE: begin
                if (start_i) begin
                    start_s     = 1'b1;
                    state_next  = S_ARM;
                    frames_next = (frames_i == '0) ? LBITS'(1) : frames_i;
                    stop_next   = 1'b0;
                end else begin
                    state_next  = S_IDLE;
                end
            end
            S_ARM: begin
                frame_next = '0;
                if (stop_i) begin
                    state_next = S_IDLE;
                end else if (valid_i && sof_i) begin
                    fwd_s      = 1'b1;
                    first_s    = 1'b1;
                    last_s     = (frames_r == LBITS'(1));
                    state_next = S_RUN;
                end else begin
                    state_next = S_ARM;
                end
            end
            S_RUN: begin
                stop_next = stop_r | stop_i;
                if (err_now_s) begin
                    state_next = S_IDLE;
                end else if (valid_i) begin
                    fwd_s   = 1'b1;
                    first_s = (frame_cnt_r == '0);
                    last_s  = last_frame_s;
                    if (eof_s && last_frame_s) begin
                        state_next = S_FLUSH;
                    end else if (eof_s) begin
                        frame_next = frame_cnt_r + LBITS'(1);
                    end else begin
                        frame_next = frame_cnt_r;
                    end
                end else begin
                    state_next = S_RUN;
                end
            end
            S_FLUSH: begin
                stop_next = stop_r | stop_i;
                if (flush_cnt_r == FLUSH_LAST) begin
                    done_s = 1'b1;
`ifdef ACCUM_SEQ_CONTINUOUS_EN
                    state_next = (stop_r | stop_i) ? S_IDLE : S_ARM;
`else
                    state_next = S_IDLE;
`endif
                end else begin
                    flush_next = flush_cnt_r + FBITS'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= S_IDLE;
            frames_r    <= '0;
            frame_cnt_r <= '0;
            flush_cnt_r <= '0;
            stop_r      <= 1'b0;
            acc_valid_r <= 1'b0;
            acc_first_r <= 1'b0;
            acc_last_r  <= 1'b0;
            acc_revis_r <= '0;
            acc_imvis_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_next;
            frames_r    <= frames_next;
            frame_cnt_r <= frame_next;
            flush_cnt_r <= flush_next;
            stop_r      <= stop_next;
            acc_valid_r <= fwd_s;
            acc_first_r <= fwd_s & first_s;
            acc_last_r  <= fwd_s & last_s;
            if (fwd_s) begin
                acc_revis_r <= revis_i;
                acc_imvis_r <= imvis_i;
            end else begin
                acc_revis_r <= acc_revis_r;
                acc_imvis_r <= acc_imvis_r;
            end
            busy_r      <= busy_state(state_next);
            done_r      <= done_s;
        end
    end

    assign acc_valid_o = acc_valid_r;
    assign acc_first_o = acc_first_r;
    assign acc_last_o  = acc_last_r;
    assign acc_revis_o = acc_revis_r;
    assign acc_imvis_o = acc_imvis_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;

endmodule

// File: tb/tb_accum_sequencer.sv
// Scoreboard bench for accum_sequencer with CORES=2, TRATE=3 (6 words/frame), ACC_LAT=3.
module tb_accum_sequencer;

    localparam int SB = 6;
    localparam int LB = 24;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_i = 1'b0, stop_i = 1'b0, valid_i = 1'b0, sof_i = 1'b0;
    logic [LB-1:0] frames_i = '0;
    logic [SB-1:0] revis_i = '0, imvis_i = '0;
    logic          acc_valid_o, acc_first_o, acc_last_o, busy_o, done_o, sync_err_o;
    logic [SB-1:0] acc_revis_o, acc_imvis_o;

    typedef struct packed {
        logic          first;
        logic          last;
        logic [SB-1:0] re;
        logic [SB-1:0] im;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            word_no = 0;
    logic [SB-1:0] dat = 6'd1;

    accum_sequencer #(.CORES(2), .TRATE(3), .ACC_LAT(3)) dut (
        .clock(clock), .reset_n(reset_n), .start_i(start_i), .stop_i(stop_i),
        .frames_i(frames_i), .valid_i(valid_i), .sof_i(sof_i),
        .revis_i(revis_i), .imvis_i(imvis_i),
        .acc_valid_o(acc_valid_o), .acc_first_o(acc_first_o), .acc_last_o(acc_last_o),
        .acc_revis_o(acc_revis_o), .acc_imvis_o(acc_imvis_o),
        .busy_o(busy_o), .done_o(done_o), .sync_err_o(sync_err_o)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare every forwarded word against the scoreboard, count done pulses.
    always @(negedge clock) begin
        if (acc_valid_o) begin
            exp_t e;
            exp_t a;
            a = {acc_first_o, acc_last_o, acc_revis_o, acc_imvis_o};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got first=%0b last=%0b re=%0h im=%0h, none expected",
                         a.first, a.last, a.re, a.im);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL word%0d: got first=%0b last=%0b re=%0h im=%0h, want first=%0b last=%0b re=%0h im=%0h",
                             word_no, a.first, a.last, a.re, a.im, e.first, e.last, e.re, e.im);
                end
            end
            word_no++;
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic sof, input logic stp, input logic exp_fwd,
                             input logic ef, input logic el);
        @(negedge clock);
        valid_i = 1'b1;
        sof_i   = sof;
        stop_i  = stp;
        revis_i = dat;
        imvis_i = ~dat;
        if (exp_fwd) exp_q.push_back('{ef, el, dat, ~dat});
        dat = dat + 6'd1;
    endtask

    // One aligned 6-word frame; stop_at >= 0 raises stop_i on that word.
    task automatic send_frame(input logic exp_fwd, input logic ef, input logic el, input int stop_at);
        for (int i = 0; i < 6; i++) begin
            send_word(i == 0, i == stop_at, exp_fwd, ef, el | (stop_at >= 0 && i >= stop_at));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            valid_i = 1'b0;
            sof_i   = 1'b0;
            stop_i  = 1'b0;
            start_i = 1'b0;
        end
    endtask

    task automatic start_int(input logic [LB-1:0] f);
        @(negedge clock);
        start_i  = 1'b1;
        frames_i = f;
        @(negedge clock);
        start_i  = 1'b0;
    endtask

    initial begin
        int d0;
        int w_cyc;
        // Reset state
        #12;
        chk("reset_outputs", {acc_valid_o, acc_first_o, acc_last_o, acc_revis_o, acc_imvis_o,
                              busy_o, done_o, sync_err_o}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(2);
        chk("idle_busy", {31'd0, busy_o}, 32'd0);

        // 1: two-frame integration
        d0 = done_cnt;
        start_int(24'd2);
        chk("t1_busy", {31'd0, busy_o}, 32'd1);
        send_frame(1'b1, 1'b1, 1'b0, -1);
        send_frame(1'b1, 1'b0, 1'b1, -1);
        @(negedge clock);
        valid_i = 1'b0; sof_i = 1'b0;
        w_cyc = cyc;
        idle(8);
        chk("t1_done_count", done_cnt - d0, 32'd1);
        chk("t1_done_latency", done_cyc - w_cyc, 32'd3);
        chk("t1_busy_after", {31'd0, busy_o}, 32'd0);

        // 2: frames_i=0 behaves as a single frame
        d0 = done_cnt;
        start_int(24'd0);
        send_frame(1'b1, 1'b1, 1'b1, -1);
        idle(8);
        chk("t2_done_count", done_cnt - d0, 32'd1);

        // 3: unaligned words before the first sof are dropped
        d0 = done_cnt;
        start_int(24'd1);
        for (int i = 0; i < 3; i++) send_word(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(1'b1, 1'b1, 1'b1, -1);
        idle(8);
        chk("t3_done_count", done_cnt - d0, 32'd1);

        // 4: early stop during frame 1 word 2
        d0 = done_cnt;
        start_int(24'd5);
        send_frame(1'b1, 1'b1, 1'b0, -1);
        send_frame(1'b1, 1'b0, 1'b0, 2);
        idle(8);
        chk("t4_done_count", done_cnt - d0, 32'd1);
        chk("t4_busy_after", {31'd0, busy_o}, 32'd0);

        // 5: sof at pair index 4 aborts the integration
        d0 = done_cnt;
        start_int(24'd3);
        send_word(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) send_word(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t5_no_err_yet", {31'd0, sync_err_o}, 32'd0);
        send_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("t5_sync_err", {31'd0, sync_err_o}, 32'd1);
        chk("t5_busy_drop", {31'd0, busy_o}, 32'd0);
        idle(8);
        chk("t5_no_done", done_cnt - d0, 32'd0);
        chk("t5_err_sticky", {31'd0, sync_err_o}, 32'd1);
        start_int(24'd1);
        chk("t5_err_cleared", {31'd0, sync_err_o}, 32'd0);
        chk("t5_rearmed", {31'd0, busy_o}, 32'd1);
        @(negedge clock);
        stop_i = 1'b1;
        idle(1);
        chk("t5_stop_in_arm", {31'd0, busy_o}, 32'd0);

        // 6: reset mid-frame clears outputs at once
        d0 = done_cnt;
        start_int(24'd2);
        send_word(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 3; i++) send_word(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_word(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #2;
        chk("t6_word_live", {31'd0, acc_valid_o}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_reset_outputs", {acc_valid_o, acc_first_o, acc_last_o, acc_revis_o, acc_imvis_o,
                                 busy_o, done_o, sync_err_o}, 32'd0);
        valid_i = 1'b0; sof_i = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        idle(8);
        chk("t6_no_done", done_cnt - d0, 32'd0);
        chk("t6_idle", {31'd0, busy_o}, 32'd0);

`ifdef ACCUM_SEQ_CONTINUOUS_EN
        // 7: continuous mode, two integrations from a single start
        d0 = done_cnt;
        start_int(24'd2);
        for (int f = 0; f < 4; f++) begin
            send_frame(1'b1, (f % 2) == 0, (f % 2) == 1, -1);
            idle(6);
        end
        chk("t7_done_count", done_cnt - d0, 32'd2);
        chk("t7_still_armed", {31'd0, busy_o}, 32'd1);
        @(negedge clock);
        stop_i = 1'b1;
        idle(2);
        chk("t7_stopped", {31'd0, busy_o}, 32'd0);
`endif

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
